inst_dispatcher: RTL and testbench

- Instruction scheduler between the host/level controller and the three Frodo execution units: memory transfer, matrix multiply, and encode/decode codec.
- Buffers 28-bit instructions in a FIFO and decodes each opcode to a target unit.
- Issues instructions in order over a valid/ready handshake and tracks per-unit busy state.
- Supports a fence instruction and illegal-opcode trapping.

---
 rtl/inst_dispatcher_if.sv | 24 ++
 rtl/inst_dispatcher.sv | 205 ++++++++++++++++++++
 tb/tb_inst_dispatcher.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_dispatcher_if.sv
// Handshake bundle between the instruction dispatcher, its host and the three
// execution units (index 0 = mem, 1 = mul, 2 = codec).
interface inst_dispatcher_if #(
    parameter int INST_WIDTH = 28
);
    logic [INST_WIDTH-1:0] inst_in;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] unit_inst;
    logic [2:0]            unit_valid;
    logic [2:0]            unit_ready;
    logic [2:0]            unit_done;
    logic [2:0]            unit_busy;

    modport master (
        output inst_in, inst_valid, unit_ready, unit_done,
        input  inst_ready, unit_inst, unit_valid, unit_busy
    );

    modport slave (
        input  inst_in, inst_valid, unit_ready, unit_done,
        output inst_ready, unit_inst, unit_valid, unit_busy
    );
endinterface

// File: rtl/inst_dispatcher.sv
// In-order instruction dispatcher: FIFO, opcode decode, per-unit busy tracking,
// fence and illegal-opcode trap. Define DISPATCH_PERF_EN for stall/issue counters.
module inst_dispatcher #(
    parameter int INST_WIDTH = 28,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    inst_dispatcher_if.slave      bus,
    output logic                  idle,
    output logic [CNT_WIDTH-1:0]  fifo_count,
    output logic                  err,
    output logic [INST_WIDTH-1:0] err_inst
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [15:0]           issued_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_FENCE = 2'd2;

    logic [INST_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [1:0]            state_q, state_d;
    logic [INST_WIDTH-1:0] unit_inst_q, unit_inst_d;
    logic [2:0]            unit_valid_q, unit_valid_d;
    logic [2:0]            unit_busy_q, unit_busy_d;
    logic                  err_q, err_d;
    logic [INST_WIDTH-1:0] err_inst_q, err_inst_d;

    logic                  full_s, empty_s, push_s, pop_s, hs_s;
    logic [INST_WIDTH-1:0] head_s;
    logic [2:0]            opcode_s, unit_sel_s;
    logic                  fence_s, illegal_s;

    assign full_s   = (count_q == CNT_WIDTH'(DEPTH));
    assign empty_s  = (count_q == {CNT_WIDTH{1'b0}});
    assign push_s   = bus.inst_valid && !full_s;
    assign head_s   = mem_q[rd_ptr_q];
    assign opcode_s = head_s[INST_WIDTH-1 -: 3];
    assign hs_s     = (state_q == ST_ISSUE) && ((unit_valid_q & bus.unit_ready) != 3'b000);

    // Opcode decode of the FIFO head into a one-hot target unit or a special op
    always_comb begin
        unit_sel_s = 3'b000;
        fence_s    = 1'b0;
        illegal_s  = 1'b0;
        case (opcode_s)
            3'b000:         unit_sel_s = 3'b001;
            3'b100, 3'b101: unit_sel_s = 3'b010;
            3'b110:         unit_sel_s = 3'b100;
            3'b111:         fence_s    = 1'b1;
            default:        illegal_s  = 1'b1;
        endcase
    end

    // Busy flags: a same-cycle handshake wins over a done pulse for that unit
    always_comb begin
        unit_busy_d = unit_busy_q & ~bus.unit_done;
        if (hs_s) begin
            unit_busy_d = unit_busy_d | unit_valid_q;
        end else begin
            unit_busy_d = unit_busy_d;
        end
    end

    // Dispatch FSM next-state and pop decision
    always_comb begin
        state_d      = state_q;
        unit_valid_d = unit_valid_q;
        unit_inst_d  = unit_inst_q;
        err_d        = err_q;
        err_inst_d   = err_inst_q;
        pop_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (empty_s) begin
                    state_d = ST_IDLE;
                end else if (fence_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_FENCE;
                end else if (illegal_s) begin
                    pop_s = 1'b1;
                    err_d = 1'b1;
                    if (!err_q) begin
                        err_inst_d = head_s;
                    end else begin
                        err_inst_d = err_inst_q;
                    end
                end else if ((unit_sel_s & unit_busy_q) == 3'b000) begin
                    unit_inst_d  = head_s;
                    unit_valid_d = unit_sel_s;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (hs_s) begin
                    pop_s        = 1'b1;
                    unit_valid_d = 3'b000;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_FENCE: begin
                if (unit_busy_d == 3'b000) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FENCE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                unit_valid_d = 3'b000;
            end
        endcase
    end

    // Occupancy update; simultaneous push and pop leave it unchanged
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // State, FIFO storage and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {INST_WIDTH{1'b0}};
            end
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_WIDTH{1'b0}};
            state_q      <= ST_IDLE;
            unit_inst_q  <= {INST_WIDTH{1'b0}};
            unit_valid_q <= 3'b000;
            unit_busy_q  <= 3'b000;
            err_q        <= 1'b0;
            err_inst_q   <= {INST_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= bus.inst_in;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q      <= count_d;
            state_q      <= state_d;
            unit_inst_q  <= unit_inst_d;
            unit_valid_q <= unit_valid_d;
            unit_busy_q  <= unit_busy_d;
            err_q        <= err_d;
            err_inst_q   <= err_inst_d;
        end
    end

    assign bus.inst_ready = !full_s;
    assign bus.unit_inst  = unit_inst_q;
    assign bus.unit_valid = unit_valid_q;
    assign bus.unit_busy  = unit_busy_q;
    assign idle           = empty_s && (unit_busy_q == 3'b000) && (state_q == ST_IDLE);
    assign fifo_count     = count_q;
    assign err            = err_q;
    assign err_inst       = err_inst_q;

`ifdef DISPATCH_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] issued_cnt_q;
    logic        stall_s;

    assign stall_s = (state_q == ST_FENCE) ||
                     ((state_q == ST_IDLE) && !empty_s && !fence_s && !illegal_s &&
                      ((unit_sel_s & unit_busy_q) != 3'b000));

    // Saturating performance counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles_q <= 32'd0;
            issued_cnt_q   <= 16'd0;
        end else begin
            if (stall_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (hs_s && (issued_cnt_q != 16'hFFFF)) begin
                issued_cnt_q <= issued_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign issued_cnt   = issued_cnt_q;
`endif
endmodule

// File: tb/tb_inst_dispatcher.sv
// Scoreboard bench for inst_dispatcher: directed stimulus queues expected issues,
// a negedge monitor pops and compares every unit handshake.
module tb_inst_dispatcher;
    localparam int W = 28;

    localparam logic [W-1:0] MEM_W   = 28'h0064040; // op 000, addr 100, len 4, port 0
    localparam logic [W-1:0] MUL0_W  = 28'h8000010; // op 100
    localparam logic [W-1:0] MUL1_W  = 28'hA000020; // op 101
    localparam logic [W-1:0] COD_W   = 28'hC000030; // op 110
    localparam logic [W-1:0] FENCE_W = 28'hE000000; // op 111
    localparam logic [W-1:0] ILL2_W  = 28'h4000123; // op 010
    localparam logic [W-1:0] ILL1_W  = 28'h2000456; // op 001
    localparam logic [W-1:0] MEM2_W  = 28'h0000777; // op 000

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    inst_dispatcher_if #(.INST_WIDTH(W)) bus ();
    logic         idle;
    logic [3:0]   fifo_count;
    logic         err;
    logic [W-1:0] err_inst;
`ifdef DISPATCH_PERF_EN
    logic [31:0]  stall_cycles;
    logic [15:0]  issued_cnt;
`endif

    inst_dispatcher #(.INST_WIDTH(W), .DEPTH(8), .CNT_WIDTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .idle       (idle),
        .fifo_count (fifo_count),
        .err        (err),
        .err_inst   (err_inst)
`ifdef DISPATCH_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .issued_cnt   (issued_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    logic [30:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every unit handshake must match the oldest expected issue
    always @(negedge clk) begin
        if (rstn && ((bus.unit_valid & bus.unit_ready) != 3'b000)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: actual=%0h required=none",
                         {bus.unit_valid, bus.unit_inst});
            end else begin
                check("issue", {1'b0, bus.unit_valid, bus.unit_inst}, {1'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] w, input logic [2:0] u);
        if (u != 3'b000) exp_q.push_back({u, w});
        bus.inst_in    = w;
        bus.inst_valid = 1'b1;
        tick();
        bus.inst_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bus.unit_ready = 3'b111;
        bus.unit_done  = 3'b111;
        repeat (40) tick();
        bus.unit_ready = 3'b000;
        bus.unit_done  = 3'b000;
        tick();
        check({name, "_idle"}, {31'd0, idle}, 32'd1);
        check({name, "_count"}, {28'd0, fifo_count}, 32'd0);
        check({name, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_inst_ready"}, {31'd0, bus.inst_ready}, 32'd1);
        check({name, "_idle"}, {31'd0, idle}, 32'd1);
        check({name, "_unit_valid"}, {29'd0, bus.unit_valid}, 32'd0);
        check({name, "_unit_busy"}, {29'd0, bus.unit_busy}, 32'd0);
        check({name, "_unit_inst"}, {4'd0, bus.unit_inst}, 32'd0);
        check({name, "_count"}, {28'd0, fifo_count}, 32'd0);
        check({name, "_err"}, {31'd0, err}, 32'd0);
        check({name, "_err_inst"}, {4'd0, err_inst}, 32'd0);
    endtask

    initial begin
        bus.inst_in    = '0;
        bus.inst_valid = 1'b0;
        bus.unit_ready = 3'b000;
        bus.unit_done  = 3'b000;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        check_reset_values("rst");

        // 1: single mem op, latency and busy/idle tracking
        bus.unit_ready = 3'b001;
        push(MEM_W, 3'b001);
        check("t1_count_after_push", {28'd0, fifo_count}, 32'd1);
        check("t1_valid_one_edge", {29'd0, bus.unit_valid}, 32'd0);
        tick();
        check("t1_valid_two_edges", {29'd0, bus.unit_valid}, 32'h1);
        check("t1_unit_inst", {4'd0, bus.unit_inst}, {4'd0, MEM_W});
        tick();
        check("t1_busy", {29'd0, bus.unit_busy}, 32'h1);
        check("t1_valid_cleared", {29'd0, bus.unit_valid}, 32'd0);
        check("t1_idle_busy", {31'd0, idle}, 32'd0);
        bus.unit_done = 3'b001;
        tick();
        bus.unit_done = 3'b000;
        check("t1_busy_cleared", {29'd0, bus.unit_busy}, 32'd0);
        check("t1_idle_done", {31'd0, idle}, 32'd1);

        // 2: second mul stalls behind busy mul unit
        bus.unit_ready = 3'b111;
        push(MEM_W, 3'b001);
        push(MUL0_W, 3'b010);
        push(MUL1_W, 3'b010);
        repeat (4) tick();
        check("t2_stall_count", {28'd0, fifo_count}, 32'd1);
        check("t2_stall_busy", {29'd0, bus.unit_busy}, 32'h3);
        check("t2_stall_valid", {29'd0, bus.unit_valid}, 32'd0);
        bus.unit_done = 3'b010;
        tick();
        bus.unit_done = 3'b000;
        check("t2_no_issue_on_done", {29'd0, bus.unit_valid}, 32'd0);
        tick();
        check("t2_issue_after_done", {29'd0, bus.unit_valid}, 32'h2);
        check("t2_issue_inst", {4'd0, bus.unit_inst}, {4'd0, MUL1_W});
        drain("t2");

        // 3: fill FIFO, full backpressure, recovery after one handshake
        bus.unit_ready = 3'b000;
        for (int i = 0; i < 8; i++) begin
            push({3'b000, 25'(i + 1)}, 3'b001);
        end
        check("t3_full_ready", {31'd0, bus.inst_ready}, 32'd0);
        check("t3_full_count", {28'd0, fifo_count}, 32'd8);
        bus.inst_in    = MEM2_W;
        bus.inst_valid = 1'b1;
        tick();
        bus.inst_valid = 1'b0;
        check("t3_ninth_rejected", {28'd0, fifo_count}, 32'd8);
        bus.unit_ready = 3'b001;
        tick();
        bus.unit_ready = 3'b000;
        check("t3_count_after_pop", {28'd0, fifo_count}, 32'd7);
        check("t3_ready_restored", {31'd0, bus.inst_ready}, 32'd1);
        drain("t3");

        // 4: fence holds younger mem op until codec completes
        bus.unit_ready = 3'b111;
        push(COD_W, 3'b100);
        push(FENCE_W, 3'b000);
        push(MEM_W, 3'b001);
        repeat (20) tick();
        check("t4_fence_valid", {29'd0, bus.unit_valid}, 32'd0);
        check("t4_fence_count", {28'd0, fifo_count}, 32'd1);
        check("t4_fence_busy", {29'd0, bus.unit_busy}, 32'h4);
        bus.unit_done = 3'b100;
        tick();
        bus.unit_done = 3'b000;
        check("t4_busy_cleared", {29'd0, bus.unit_busy}, 32'd0);
        check("t4_not_yet_issued", {29'd0, bus.unit_valid}, 32'd0);
        tick();
        check("t4_mem_issued", {29'd0, bus.unit_valid}, 32'h1);
        check("t4_mem_inst", {4'd0, bus.unit_inst}, {4'd0, MEM_W});
        drain("t4");

        // 5: illegal opcodes trap, first one captured
        push(ILL2_W, 3'b000);
        push(ILL1_W, 3'b000);
        repeat (3) tick();
        check("t5_err", {31'd0, err}, 32'd1);
        check("t5_err_inst", {4'd0, err_inst}, {4'd0, ILL2_W});
        check("t5_count", {28'd0, fifo_count}, 32'd0);
        check("t5_valid", {29'd0, bus.unit_valid}, 32'd0);
        check("t5_idle", {31'd0, idle}, 32'd1);

        // 6: done coinciding with handshake, then reset mid-issue
        push(MUL0_W, 3'b010);
        tick();
        check("t6_issue_mul", {29'd0, bus.unit_valid}, 32'h2);
        bus.unit_ready = 3'b010;
        bus.unit_done  = 3'b010;
        tick();
        bus.unit_ready = 3'b000;
        bus.unit_done  = 3'b000;
        check("t6_busy_kept", {29'd0, bus.unit_busy}, 32'h2);
        push(MEM2_W, 3'b001);
        tick();
        check("t6_mid_issue_valid", {29'd0, bus.unit_valid}, 32'h1);
        #2 rstn = 1'b0;
        exp_q.delete();
        #1;
        check_reset_values("t6_async_rst");
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();
        check_reset_values("t6_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
